// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_ctrl : HI/LO multiply/divide sequencer for the MIPS EX stage.     |
// | Optional macro DIV_ZERO_FAST_EN: divide-by-zero completes in one cycle.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module muldiv_ctrl #(
  parameter int MUL_LAT   = 2,
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  input  logic        wr_hi_i,
  input  logic        wr_lo_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [5:0] c_MUL_LAST = 6'(MUL_LAT - 1);
  localparam logic [5:0] c_DIV_LAST = 6'(DIV_STEPS - 1);

  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [31:0] r_a, r_b, r_quo, r_rem, r_hi, r_lo;
  logic        r_neg_q, r_neg_r;

  logic        w_accept, w_sa, w_sb, w_fast_dz, w_ge;
  logic [31:0] w_abs_a, w_abs_b, w_sub, w_rem_nxt, w_quo_nxt;
  logic [32:0] w_shift;
  logic [63:0] w_prod, w_prod_fix;

  assign w_accept = (r_state == S_IDLE) & start_i & ~flush_i;
  assign w_sa     = ~op_i[0] & a_i[31];
  assign w_sb     = ~op_i[0] & b_i[31];
  assign w_abs_a  = w_sa ? -a_i : a_i;
  assign w_abs_b  = w_sb ? -b_i : b_i;

`ifdef DIV_ZERO_FAST_EN
  assign w_fast_dz = op_i[1] & (b_i == 32'd0);
`else
  assign w_fast_dz = 1'b0;
`endif

  // Magnitude product, sign applied afterwards; equals the 33x33 signed product.
  assign w_prod     = {32'd0, r_a} * {32'd0, r_b};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  // Restoring step: partial remainder always < divisor, so the difference fits 32 bits.
  assign w_shift   = {r_rem, r_quo[31]};
  assign w_ge      = w_shift >= {1'b0, r_b};
  assign w_sub     = w_shift[31:0] - r_b;
  assign w_rem_nxt = w_ge ? w_sub : w_shift[31:0];
  assign w_quo_nxt = {r_quo[30:0], w_ge};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) w_next = w_fast_dz ? S_DONE : (op_i[1] ? S_DIV : S_MUL);
        S_MUL:  if (r_cnt == c_MUL_LAST) w_next = S_DONE;
        S_DIV:  if (r_cnt == c_DIV_LAST) w_next = S_FIX;
        S_FIX:  w_next = S_DONE;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= 6'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_quo   <= 32'd0;
      r_rem   <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (!flush_i) begin
      case (r_state)
        S_IDLE: begin
          if (wr_hi_i) r_hi <= wdata_i;
          if (wr_lo_i) r_lo <= wdata_i;
          if (w_accept) begin
            r_a     <= w_abs_a;
            r_b     <= w_abs_b;
            r_quo   <= w_abs_a;
            r_rem   <= 32'd0;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_cnt   <= 6'd0;
            if (w_fast_dz) begin
              r_hi <= a_i;
              r_lo <= 32'hFFFF_FFFF;
            end
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == c_MUL_LAST) {r_hi, r_lo} <= w_prod_fix;
        end
        S_DIV: begin
          r_cnt <= r_cnt + 6'd1;
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
        end
        S_FIX: begin
          r_lo <= r_neg_q ? -r_quo : r_quo;
          r_hi <= r_neg_r ? -r_rem : r_rem;
        end
        default: ;
      endcase
    end
  end

  assign stall_o = w_accept | (r_state == S_MUL) | (r_state == S_DIV) | (r_state == S_FIX);
  assign done_o  = (r_state == S_DONE);
  assign busy_o  = (r_state != S_IDLE);
  assign hi_o    = r_hi;
  assign lo_o    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_muldiv_ctrl : directed self-checking bench for muldiv_ctrl.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        wr_hi_i = 1'b0;
  logic        wr_lo_i = 1'b0;
  logic [31:0] wdata_i = 32'd0;
  logic        stall_o, done_o, busy_o;
  logic [31:0] hi_o, lo_o;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_ctrl dut (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .wr_hi_i (wr_hi_i),
    .wr_lo_i (wr_lo_i),
    .wdata_i (wdata_i),
    .stall_o (stall_o),
    .done_o  (done_o),
    .busy_o  (busy_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents the op in cycle T, returns in cycle T+1 with start_i dropped.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    tick();
    start_i = 1'b0;
  endtask

  // Returns the cycle offset from T at which done_o is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done_o && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  int lat;
  int n_done;
  int exp_dz_lat;

  initial begin
`ifdef DIV_ZERO_FAST_EN
    exp_dz_lat = 1;
`else
    exp_dz_lat = 34;
`endif
    // Reset state
    #2;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    start_i = 1'b1;
    #1;
    chk("rst_stall_start", {31'd0, stall_o}, 32'd1);
    start_i = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();

    // MULT 0xFFFFFFFE * 3 = -6
    start_i = 1'b1; op_i = 2'b00; a_i = 32'hFFFF_FFFE; b_i = 32'd3;
    #1;
    chk("mult_stall_T", {31'd0, stall_o}, 32'd1);
    tick();
    start_i = 1'b0;
    chk("mult_stall_T1", {31'd0, stall_o}, 32'd1);
    chk("mult_busy_T1", {31'd0, busy_o}, 32'd1);
    chk("mult_done_T1", {31'd0, done_o}, 32'd0);
    tick();
    chk("mult_stall_T2", {31'd0, stall_o}, 32'd1);
    chk("mult_done_T2", {31'd0, done_o}, 32'd0);
    tick();
    chk("mult_done_T3", {31'd0, done_o}, 32'd1);
    chk("mult_stall_T3", {31'd0, stall_o}, 32'd0);
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFFA);
    tick();
    chk("mult_done_T4", {31'd0, done_o}, 32'd0);
    chk("mult_busy_T4", {31'd0, busy_o}, 32'd0);

    // MULTU same operands; start_i held in DONE must be ignored
    start_op(2'b01, 32'hFFFF_FFFE, 32'd3);
    wait_done(lat);
    chk("multu_lat", lat, 32'd3);
    chk("multu_hi", hi_o, 32'h0000_0002);
    chk("multu_lo", lo_o, 32'hFFFF_FFFA);
    start_i = 1'b1;
    #1;
    chk("done_start_stall", {31'd0, stall_o}, 32'd0);
    tick();
    start_i = 1'b0;
    chk("done_start_busy", {31'd0, busy_o}, 32'd0);

    // MULT most-negative squared = 2^62
    start_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat);
    chk("mult_min_hi", hi_o, 32'h4000_0000);
    chk("mult_min_lo", lo_o, 32'h0000_0000);
    tick();

    // DIV -7 / 2 = -3 rem -1
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    chk("div_lat", lat, 32'd34);
    chk("div_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_hi", hi_o, 32'hFFFF_FFFF);
    tick();

    // DIVU 100 / 7 = 14 rem 2
    start_op(2'b11, 32'd100, 32'd7);
    wait_done(lat);
    chk("divu_lat", lat, 32'd34);
    chk("divu_lo", lo_o, 32'h0000_000E);
    chk("divu_hi", hi_o, 32'h0000_0002);
    tick();

    // MTHI then MTLO
    wr_hi_i = 1'b1; wdata_i = 32'h1234_5678;
    tick();
    wr_hi_i = 1'b0;
    chk("mthi_hi", hi_o, 32'h1234_5678);
    chk("mthi_lo_keep", lo_o, 32'h0000_000E);
    wr_lo_i = 1'b1; wdata_i = 32'h9ABC_DEF0;
    tick();
    wr_lo_i = 1'b0;
    chk("mtlo_lo", lo_o, 32'h9ABC_DEF0);
    chk("mtlo_hi_keep", hi_o, 32'h1234_5678);

    // DIVU flushed at T+10
    start_op(2'b11, 32'd100, 32'd7);
    repeat (9) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    chk("flush_done", {31'd0, done_o}, 32'd0);
    chk("flush_hi", hi_o, 32'h1234_5678);
    chk("flush_lo", lo_o, 32'h9ABC_DEF0);
    n_done = 0;
    repeat (40) begin
      if (done_o) n_done++;
      tick();
    end
    chk("flush_no_done", n_done, 32'd0);

    // start_i together with flush_i is dropped
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'b01; a_i = 32'd9; b_i = 32'd9;
    #1;
    chk("sflush_stall", {31'd0, stall_o}, 32'd0);
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    chk("sflush_busy", {31'd0, busy_o}, 32'd0);
    chk("sflush_lo", lo_o, 32'h9ABC_DEF0);

    // DIVU 5 / 0
    start_op(2'b11, 32'd5, 32'd0);
    wait_done(lat);
    chk("divz_lat", lat, exp_dz_lat);
    chk("divz_lo", lo_o, 32'hFFFF_FFFF);
    chk("divz_hi", hi_o, 32'h0000_0005);
    tick();

    // Asynchronous reset in the middle of a divide
    start_op(2'b11, 32'd100, 32'd7);
    repeat (5) tick();
    chk("mid_busy_pre", {31'd0, busy_o}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_hi", hi_o, 32'd0);
    chk("mid_rst_lo", lo_o, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
